// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and clear-sweep state encoding for regfile_mp.
package regfile_pkg;
   localparam int DEF_DATA_W = 64;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_RD = 2;
   typedef enum logic {IDLE, SWEEP} clr_state_e;
endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: bulk-clear sequencer, zeroes one register index per cycle while sweeping.
module regfile_clr_fsm
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              ClrReq,
   output logic [ADDR_W-1:0] clr_idx,
   output logic              clr_en,
   output logic              ClrBusy,
   output logic              ClrDone
);
   localparam logic [ADDR_W-1:0] LAST = '1;
   clr_state_e        state;
   logic [ADDR_W-1:0] cnt;
   logic              last;
   assign last    = cnt == LAST;
   assign ClrBusy = state == SWEEP;
   assign ClrDone = ClrBusy && last;
   assign clr_en  = ClrBusy;
   assign clr_idx = cnt;
   // the counter idles at 0, so entering the sweep needs no explicit load
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (state == IDLE) begin
         state <= ClrReq ? SWEEP : IDLE;
         cnt   <= '0;
      end else begin
         state <= last ? IDLE : SWEEP;
         cnt   <= last ? '0 : cnt + ADDR_W'(1);
      end
   end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with hardwired-zero index and bulk clear sweep.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_IDX = 2**ADDR_W-1
) (
   input  logic                     Clk,
   input  logic                     Reset_n,
   input  logic [NUM_RD*ADDR_W-1:0] RA,
   output logic [NUM_RD*DATA_W-1:0] BusR,
   input  logic [ADDR_W-1:0]        RW,
   input  logic [DATA_W-1:0]        BusW,
   input  logic                     RegWr,
   input  logic                     ClrReq,
   output logic                     ClrBusy,
   output logic                     ClrDone
);
   localparam int                DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZI    = ADDR_W'(ZERO_IDX);
   logic [DATA_W-1:0] regs [DEPTH];
   logic [ADDR_W-1:0] clr_idx;
   logic              clr_en;
   logic              wr_en;
   regfile_clr_fsm #(.ADDR_W(ADDR_W)) u_clr (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .ClrReq  (ClrReq),
      .clr_idx (clr_idx),
      .clr_en  (clr_en),
      .ClrBusy (ClrBusy),
      .ClrDone (ClrDone)
   );
   assign wr_en = RegWr && !ClrBusy && RW != ZI;
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (clr_en) begin
         regs[clr_idx] <= '0;
      end else if (wr_en) begin
         regs[RW] <= BusW;
      end
   end
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      assign a = RA[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
      assign BusR[k*DATA_W +: DATA_W] = (a == ZI) ? '0 : (wr_en && a == RW) ? BusW : regs[a];
`else
      assign BusR[k*DATA_W +: DATA_W] = (a == ZI) ? '0 : regs[a];
`endif
   end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized scoreboard bench for regfile_mp against an array-level reference model.
module tb_regfile_mp;
   logic         Clk = 1'b0;
   logic         Reset_n;
   logic [9:0]   RA;
   logic [127:0] BusR;
   logic [4:0]   RW;
   logic [63:0]  BusW;
   logic         RegWr, ClrReq, ClrBusy, ClrDone;
   logic [19:0]  RA4;
   logic [127:0] BusR4;
   logic [4:0]   RW4;
   logic [31:0]  BusW4;
   logic         RegWr4, ClrBusy4, ClrDone4;

   always #5 Clk = ~Clk;

   regfile_mp dut (
      .Clk(Clk), .Reset_n(Reset_n), .RA(RA), .BusR(BusR), .RW(RW), .BusW(BusW),
      .RegWr(RegWr), .ClrReq(ClrReq), .ClrBusy(ClrBusy), .ClrDone(ClrDone)
   );

   regfile_mp #(.DATA_W(32), .NUM_RD(4)) dut4 (
      .Clk(Clk), .Reset_n(Reset_n), .RA(RA4), .BusR(BusR4), .RW(RW4), .BusW(BusW4),
      .RegWr(RegWr4), .ClrReq(1'b0), .ClrBusy(ClrBusy4), .ClrDone(ClrDone4)
   );

`ifdef REGFILE_BYPASS_EN
   localparam logic [63:0] FWD = 64'hAA;
`else
   localparam logic [63:0] FWD = 64'h55;
`endif

   typedef struct {
      int          kind;
      logic [63:0] exp;
      string       name;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          cyc_n = 0;
   logic [63:0] mem [32];
   bit          busy;
   int          pos;

   // reference model: storage array plus "sweep in progress at position pos"
   function automatic logic [63:0] rd_model(input logic [4:0] a);
      if (a == 5'd31) return 64'h0;
`ifdef REGFILE_BYPASS_EN
      if (RegWr && !busy && RW != 5'd31 && a == RW) return BusW;
`endif
      return mem[a];
   endfunction

   function automatic void push(input int kind, input logic [63:0] v, input string nm);
      exp_t e;
      e.kind = kind;
      e.exp  = v;
      e.name = nm;
      sb.push_back(e);
   endfunction

   task automatic model_reset();
      foreach (mem[i]) mem[i] = 64'h0;
      busy = 0;
      pos  = 0;
   endtask

   task automatic model_edge();
      if (busy) begin
         mem[pos] = 64'h0;
         pos++;
         if (pos == 32) begin
            busy = 0;
            pos  = 0;
         end
      end else begin
         if (RegWr && RW != 5'd31) mem[RW] = BusW;
         if (ClrReq) begin
            busy = 1;
            pos  = 0;
         end
      end
   endtask

   task automatic expect_all();
      push(0, rd_model(RA[4:0]), "rd0");
      push(1, rd_model(RA[9:5]), "rd1");
      push(2, {63'b0, busy}, "busy");
      push(3, {63'b0, busy && pos == 31}, "done");
   endtask

   task automatic cyc();
      expect_all();
      @(posedge Clk);
      model_edge();
      #1;
      cyc_n++;
   endtask

   task automatic set_in(input bit we, input logic [4:0] rw, input logic [63:0] bw,
                         input logic [4:0] r0, input logic [4:0] r1, input bit clr);
      RegWr  = we;
      RW     = rw;
      BusW   = bw;
      RA     = {r1, r0};
      ClrReq = clr;
   endtask

   task automatic drive(input bit we, input logic [4:0] rw, input logic [63:0] bw,
                        input logic [4:0] r0, input logic [4:0] r1, input bit clr);
      set_in(we, rw, bw, r0, r1, clr);
      cyc();
   endtask

   always @(negedge Clk) begin
      exp_t        e;
      logic [63:0] act;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            0:       act = BusR[63:0];
            1:       act = BusR[127:64];
            2:       act = {63'b0, ClrBusy};
            3:       act = {63'b0, ClrDone};
            8:       act = {63'b0, ClrBusy4 | ClrDone4};
            default: act = {32'b0, BusR4[(e.kind-4)*32 +: 32]};
         endcase
         n_chk++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", e.name, cyc_n, act, e.exp);
         end
      end
   end

   initial begin
      Reset_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      RA4 = '0; RW4 = '0; BusW4 = '0; RegWr4 = 1'b0;
      model_reset();
      repeat (2) @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      for (int i = 0; i < 32; i++) drive(0, 0, 0, 5'(i), 5'(31 - i), 0);
      drive(1, 5, 64'hDEADBEEF_CAFEF00D, 0, 0, 0);
      drive(0, 0, 0, 5, 5, 0);
      drive(1, 31, 64'h1234, 31, 31, 0);
      drive(0, 0, 0, 31, 31, 0);
      drive(1, 7, 64'h55, 0, 0, 0);
      set_in(1, 7, 64'hAA, 0, 7, 0);
      push(1, FWD, "fwd7");
      cyc();
      drive(0, 0, 0, 7, 7, 0);
      for (int i = 0; i < 31; i++) drive(1, 5'(i), 64'(i + 1), 5'(i), 5'(i), 0);
      drive(0, 0, 0, 3, 30, 1);
      for (int c = 0; c < 32; c++) begin
         if (c == 9) set_in(1, 3, 64'h9, 3, 5'(c), 0);
         else        set_in(0, 0, 0, 5'(c), 3, c == 5);
         cyc();
      end
      for (int i = 0; i < 32; i++) drive(0, 0, 0, 5'(i), 5'(31 - i), 0);
      // sweep aborted by reset partway through
      for (int i = 0; i < 31; i++) drive(1, 5'(i), 64'(100 + i), 0, 0, 0);
      drive(0, 0, 0, 4, 20, 1);
      for (int c = 0; c < 8; c++) drive(0, 0, 0, 5'(c), 20, 0);
      Reset_n = 1'b0;
      model_reset();
      #1;
      expect_all();
      @(posedge Clk);
      #1;
      Reset_n = 1'b1;
      for (int i = 0; i < 32; i++) drive(0, 0, 0, 5'(i), 5'(31 - i), 0);
      for (int i = 0; i < 400; i++) begin
         logic [4:0] rw, r0, r1;
         rw = 5'($urandom);
         r0 = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
         r1 = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom);
         drive(1'($urandom), rw, {$urandom, $urandom}, r0, r1, $urandom_range(0, 63) == 0);
      end
      set_in(0, 0, 0, 0, 0, 0);
      RegWr4 = 1'b1;
      RW4 = 5'd1; BusW4 = 32'h11; cyc();
      RW4 = 5'd2; BusW4 = 32'h22; cyc();
      RW4 = 5'd3; BusW4 = 32'h33; cyc();
      RW4 = 5'd31; BusW4 = 32'h44; cyc();
      RegWr4 = 1'b0;
      RA4 = {5'd31, 5'd3, 5'd2, 5'd1};
      push(4, 64'h11, "p4_0");
      push(5, 64'h22, "p4_1");
      push(6, 64'h33, "p4_2");
      push(7, 64'h0, "p4_3");
      push(8, 64'h0, "p4_busy");
      cyc();
      @(negedge Clk);
      #1;
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
